// File: rtl/tdm_demux4_pkg.sv
// Shared types and constants for the 4-slot TDM receive demultiplexer.
package tdm_demux4_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_e;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

endpackage

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demultiplexer: locks onto start-of-frame markers, stages slots 0..2
// and publishes a complete frame in parallel when the slot-3 word arrives.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     out_valid,
  output logic [SLOT_W-1:0]        slot,
  output logic                     locked,
  output logic                     frame_err
);

  state_e                    state_q;
  logic [SLOT_W-1:0]         slot_q;
  logic [DATA_W-1:0]         stage_q [NUM_CH-1];
  logic [NUM_CH*DATA_W-1:0]  out_data_q;
  logic                      out_valid_q;
  logic                      frame_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH - 1; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            if (in_sof) begin
              stage_q[0] <= in_data;
              slot_q     <= 2'd1;
              state_q    <= SYNC;
            end
          end
          SYNC: begin
            if (in_sof) begin
              // An early SOF restarts the frame; the stale partial is simply overwritten.
              frame_err_q <= (slot_q != 2'd0);
              stage_q[0]  <= in_data;
              slot_q      <= 2'd1;
            end else if (slot_q == 2'd0) begin
              frame_err_q <= 1'b1;
              state_q     <= HUNT;
            end else if (slot_q == 2'd3) begin
              out_data_q  <= {in_data, stage_q[2], stage_q[1], stage_q[0]};
              out_valid_q <= 1'b1;
              slot_q      <= 2'd0;
            end else begin
              stage_q[slot_q] <= in_data;
              slot_q          <= slot_q + 2'd1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign locked    = (state_q == SYNC);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed vector table, async-reset sequence,
// and randomized traffic compared against a frame-level queue model.
module tb_tdm_demux4;

  localparam int DW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic        in_sof = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic [1:0]  slot;
  logic        locked;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_data  (out_data),
    .out_valid (out_valid),
    .slot      (slot),
    .locked    (locked),
    .frame_err (frame_err)
  );

  // Frame-level reference: a queue of the words collected for the current frame.
  bit          m_locked;
  logic [3:0]  m_part [$];
  logic [15:0] m_out;
  bit          m_valid;
  bit          m_err;

  task automatic model_reset();
    m_locked = 0;
    m_part.delete();
    m_out   = '0;
    m_valid = 0;
    m_err   = 0;
  endtask

  task automatic model_step(input bit v, input bit sof, input logic [3:0] d);
    m_valid = 0;
    m_err   = 0;
    if (v) begin
      if (!m_locked) begin
        if (sof) begin
          m_locked = 1;
          m_part   = '{d};
        end
      end else if (sof) begin
        if (m_part.size() != 0) m_err = 1;
        m_part = '{d};
      end else if (m_part.size() == 0) begin
        m_err    = 1;
        m_locked = 0;
      end else begin
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          m_out   = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_valid = 1;
          m_part.delete();
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input logic [15:0] ed, input bit ev, input logic [1:0] es,
                           input bit el, input bit ee);
    chk("out_data",  out_data,         ed);
    chk("out_valid", {15'd0, out_valid}, {15'd0, ev});
    chk("slot",      {14'd0, slot},      {14'd0, es});
    chk("locked",    {15'd0, locked},    {15'd0, el});
    chk("frame_err", {15'd0, frame_err}, {15'd0, ee});
  endtask

  task automatic drive_cycle(input bit v, input bit sof, input logic [3:0] d);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    @(posedge clk);
    #1;
    model_step(v, sof, d);
  endtask

  typedef struct {
    bit          v;
    bit          sof;
    logic [3:0]  d;
    logic [15:0] ed;
    bit          ev;
    logic [1:0]  es;
    bit          el;
    bit          ee;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input bit v, input bit sof, input logic [3:0] d, input logic [15:0] ed,
                     input bit ev, input logic [1:0] es, input bit el, input bit ee);
    vec_t t;
    t = '{v, sof, d, ed, ev, es, el, ee};
    vecs.push_back(t);
  endtask

  initial begin
    int gslot;
    bit v, sof;
    logic [3:0] d;

    model_reset();
    // Non-SOF words while hunting are discarded.
    add(1, 0, 4'h1, 16'h0000, 0, 2'd0, 0, 0);
    add(1, 0, 4'h2, 16'h0000, 0, 2'd0, 0, 0);
    // Back-to-back frame.
    add(1, 1, 4'h1, 16'h0000, 0, 2'd1, 1, 0);
    add(1, 0, 4'h2, 16'h0000, 0, 2'd2, 1, 0);
    add(1, 0, 4'h3, 16'h0000, 0, 2'd3, 1, 0);
    add(1, 0, 4'h4, 16'h4321, 1, 2'd0, 1, 0);
    // Gapped frame followed directly by a second frame.
    add(1, 1, 4'h1, 16'h4321, 0, 2'd1, 1, 0);
    add(1, 0, 4'h2, 16'h4321, 0, 2'd2, 1, 0);
    add(0, 0, 4'hF, 16'h4321, 0, 2'd2, 1, 0);
    add(0, 1, 4'hE, 16'h4321, 0, 2'd2, 1, 0);
    add(0, 0, 4'hD, 16'h4321, 0, 2'd2, 1, 0);
    add(1, 0, 4'h3, 16'h4321, 0, 2'd3, 1, 0);
    add(1, 0, 4'h4, 16'h4321, 1, 2'd0, 1, 0);
    add(1, 1, 4'hA, 16'h4321, 0, 2'd1, 1, 0);
    add(1, 0, 4'hB, 16'h4321, 0, 2'd2, 1, 0);
    add(1, 0, 4'hC, 16'h4321, 0, 2'd3, 1, 0);
    add(1, 0, 4'hD, 16'hDCBA, 1, 2'd0, 1, 0);
    // Early SOF discards the partial frame.
    add(1, 1, 4'h5, 16'hDCBA, 0, 2'd1, 1, 0);
    add(1, 0, 4'h6, 16'hDCBA, 0, 2'd2, 1, 0);
    add(1, 1, 4'h7, 16'hDCBA, 0, 2'd1, 1, 1);
    add(1, 0, 4'h8, 16'hDCBA, 0, 2'd2, 1, 0);
    add(1, 0, 4'h9, 16'hDCBA, 0, 2'd3, 1, 0);
    add(1, 0, 4'hA, 16'hA987, 1, 2'd0, 1, 0);
    // Missing SOF drops lock; relock on the next SOF.
    add(1, 1, 4'h1, 16'hA987, 0, 2'd1, 1, 0);
    add(1, 0, 4'h2, 16'hA987, 0, 2'd2, 1, 0);
    add(1, 0, 4'h3, 16'hA987, 0, 2'd3, 1, 0);
    add(1, 0, 4'h4, 16'h4321, 1, 2'd0, 1, 0);
    add(1, 0, 4'h5, 16'h4321, 0, 2'd0, 0, 1);
    add(1, 0, 4'h6, 16'h4321, 0, 2'd0, 0, 0);
    add(1, 0, 4'h7, 16'h4321, 0, 2'd0, 0, 0);
    add(1, 1, 4'h8, 16'h4321, 0, 2'd1, 1, 0);
    add(1, 0, 4'h9, 16'h4321, 0, 2'd2, 1, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all(16'h0000, 0, 2'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all(16'h0000, 0, 2'd0, 0, 0);

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].v, vecs[i].sof, vecs[i].d);
      check_all(vecs[i].ed, vecs[i].ev, vecs[i].es, vecs[i].el, vecs[i].ee);
    end

    // Mid-frame async reset after the slot-2 word: state clears without a clock edge.
    drive_cycle(1, 0, 4'hA);
    check_all(16'h4321, 0, 2'd3, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all(16'h0000, 0, 2'd0, 0, 0);
    model_reset();
    #1 rst_n = 1'b1;
    drive_cycle(1, 0, 4'hB);
    check_all(16'h0000, 0, 2'd0, 0, 0);

    // Randomized traffic against the queue model.
    gslot = 0;
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      sof = (gslot == 0);
      if ($urandom_range(0, 11) == 0) sof = !sof;
      d = 4'($urandom_range(0, 15));
      if (v) gslot = sof ? 1 : (gslot + 1) % 4;
      drive_cycle(v, sof, d);
      check_all(m_out, m_valid, 2'(m_part.size()), m_locked, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division 1-to-4 demultiplexer: the receive-side counterpart of the team's 4:1 selector.
- Accepts one DATA_W-bit word per valid cycle on a single interleaved lane, tagged with a start-of-frame marker.
- Steers slots 0..3 of each frame into four channel lanes and presents a complete frame in parallel with a one-cycle valid pulse.
- Sits between a serial/TDM link and per-channel consumers.

Parameters:
- DATA_W, 4, width of each channel word.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  in_data/in_sof qualify this cycle
- in_data  input  DATA_W  incoming slot word
- in_sof  input  1  marks the word as slot 0 of a frame; ignored when in_valid=0
- out_data  output  4*DATA_W  frame; ch0 in [DATA_W-1:0], ch3 in MSBs
- out_valid  output  1  one-cycle pulse: out_data holds a new complete frame
- slot  output  2  slot index expected for the next accepted word
- locked  output  1  1 while in SYNC state
- frame_err  output  1  one-cycle pulse on framing violation

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low, clock port clk, reset port rst_n.
- Reset values: out_data=0, out_valid=0, slot=0, locked=0, frame_err=0, staging regs=0, state=HUNT.
- Only cycles with in_valid=1 are accepted words. No backpressure: the block is always ready.
- State HUNT:
  - Words without in_sof are discarded; slot stays 0.
  - An accepted word with in_sof=1 is stored as ch0, slot becomes 1, state goes to SYNC.
- State SYNC:
  - Accepted word with slot=1..2 and in_sof=0: stored in stage[slot], slot increments.
  - Accepted word with slot=3 and in_sof=0: out_data is loaded with {in_data, stage2, stage1, stage0} on the next edge. out_valid pulses 1 for that one cycle. slot wraps to 0.
  - Accepted word with slot=0 and in_sof=1: stored as ch0, slot becomes 1. This is normal back-to-back frame continuation.
- Framing violations in SYNC:
  - in_sof=1 arriving at slot≠0 (early SOF): frame_err pulses, the partial frame is discarded, and this word becomes ch0 of a new frame (slot=1). State stays SYNC.
  - in_sof=0 arriving at slot=0 (missing SOF): frame_err pulses, the word is discarded, slot=0, state goes to HUNT.
- Latency: out_data/out_valid are registered and update on the edge that accepts the slot-3 word; they are visible the following cycle.
- out_data holds its last frame until the next complete frame; it is never partially updated.
- Gaps (in_valid=0) of any length mid-frame are allowed; slot and staging hold.
- out_valid and frame_err are never asserted in the same cycle.
- Reset asserted mid-frame: all state clears immediately and asynchronously, including out_data. After release the block starts in HUNT.
- Width: slot is 2-bit with natural wrap from 3 to 0; no other arithmetic.

Decomposition:
- Shared package holds:
  - state enum (HUNT=1'b0, SYNC=1'b1)
  - constant NUM_CH=4
  - constant SLOT_W=2
- No sub-module required. The slot counter/FSM and the staging/output registers live in one module.

Test Plan:
- Reset, then in_valid pulses carrying 4'h1,4'h2 with in_sof=0 -> discarded, locked=0, slot=0, out_valid never asserts.
- Frame sof+4'h1, 4'h2, 4'h3, 4'h4 on consecutive cycles -> locked=1 after the first word; one cycle after the 4'h4 word, out_data=16'h4321 and out_valid=1 for exactly one cycle; slot=0.
- Same frame with 3 idle cycles between slots 1 and 2, followed directly by a second frame 4'hA..4'hD -> first output 16'h4321, then 16'hDCBA. frame_err stays 0 and out_data holds between frames.
- After lock, send sof+4'h5, 4'h6, then sof+4'h7, 4'h8, 4'h9, 4'hA -> frame_err pulses once at the second SOF, 16'h??65 is never output, and the next output is 16'hA987.
- After lock, send a complete frame, then a word with in_sof=0 at slot 0 -> frame_err pulse, locked=0. Subsequent non-SOF words are ignored until sof+word relocks.
- Assert rst_n=0 for one cycle after the slot-2 word of a frame -> out_data=0, slot=0, and locked=0 asynchronously. The following slot-3 word is discarded with no out_valid.
